// File: rtl/gearbox_rx_if.sv
// Block-side bus of the receive gearbox: one PMA word in per cycle, one 66-bit block out.
// The producer/consumer side uses master, the gearbox uses slave.
interface gearbox_rx_if #(
    parameter int PMA_W        = 64,
    parameter int HEAD_W       = 2,
    parameter int BLOCK_DATA_W = 64,
    parameter int CNT_W        = 7
);
    logic [PMA_W-1:0]        data_i;
    logic                    slip_i;
    logic                    valid_o;
    logic [HEAD_W-1:0]       head_o;
    logic [BLOCK_DATA_W-1:0] data_o;
    logic [CNT_W-1:0]        fill_o;

    modport master (
        output data_i, slip_i,
        input  valid_o, head_o, data_o, fill_o
    );

    modport slave (
        input  data_i, slip_i,
        output valid_o, head_o, data_o, fill_o
    );
endinterface

// File: rtl/gearbox_rx.sv
// Receive 64b/66b gearbox: packs PMA words (LSB oldest) into 66-bit blocks {payload, header}.
// A residue buffer holds up to 65 leftover bits; slip_i drops the oldest unconsumed bit.
module gearbox_rx #(
    parameter int PMA_W        = 64,
    parameter int HEAD_W       = 2,
    parameter int BLOCK_DATA_W = 64,
    parameter int BLOCK_W      = BLOCK_DATA_W + HEAD_W,
    parameter int CNT_W        = $clog2(BLOCK_W)
) (
    input  logic      clk,
    input  logic      reset,
    gearbox_rx_if.slave bus
);
    localparam int BUF_W = BLOCK_W - 1;
    localparam int WIN_W = BUF_W + PMA_W;

    logic [BUF_W-1:0]        r_buf;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_valid;
    logic [HEAD_W-1:0]       r_head;
    logic [BLOCK_DATA_W-1:0] r_data;

    logic [BUF_W-1:0]        w_buf_live;
    logic [WIN_W-1:0]        w_win_raw;
    logic [WIN_W-1:0]        w_win;
    logic [CNT_W:0]          w_avail;
    logic                    w_emit;
    logic [BUF_W-1:0]        w_buf_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    // Stale bits above the fill level are masked so they can never reach a block.
    always_comb begin
        w_buf_live = '0;
        for (int i = 0; i < BUF_W; i++) begin
            w_buf_live[i] = r_buf[i] && (i < int'(r_cnt));
        end
    end

    always_comb begin
        w_win_raw = {{PMA_W{1'b0}}, w_buf_live}
                  | ({{BUF_W{1'b0}}, bus.data_i} << r_cnt);
        w_win     = bus.slip_i ? (w_win_raw >> 1) : w_win_raw;
        w_avail   = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(PMA_W) - (CNT_W+1)'(bus.slip_i);
        w_emit    = (w_avail >= (CNT_W+1)'(BLOCK_W));
    end

    // Without an emit avail is at most 65, so the whole window fits the buffer.
    always_comb begin
        if (w_emit) begin
            w_buf_nxt = BUF_W'(w_win >> BLOCK_W);
            w_cnt_nxt = CNT_W'(w_avail - (CNT_W+1)'(BLOCK_W));
        end else begin
            w_buf_nxt = BUF_W'(w_win);
            w_cnt_nxt = CNT_W'(w_avail);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_data  <= '0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_emit;
            if (w_emit) begin
                r_head <= w_win[HEAD_W-1:0];
                r_data <= w_win[BLOCK_W-1:HEAD_W];
            end
        end
    end

    assign bus.valid_o = r_valid;
    assign bus.head_o  = r_head;
    assign bus.data_o  = r_data;
    assign bus.fill_o  = r_cnt;
endmodule

// File: tb/tb_gearbox_rx.sv
// Directed bench for gearbox_rx: table-driven 32-block stream plus slip, reset,
// offset-alignment, long loopback and a 32-bit PMA instance.
module tb_gearbox_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gearbox_rx_if #(.PMA_W(64)) b64();
    gearbox_rx_if #(.PMA_W(32)) b32();

    gearbox_rx #(.PMA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));
    gearbox_rx #(.PMA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));

    int n_chk  = 0;
    int n_pass = 0;

    bit bq[$];

    typedef struct {
        logic [63:0] data;
        logic        slip;
        logic        valid;
        logic [1:0]  head;
        logic [63:0] pay;
        logic [6:0]  fill;
    } vec_t;
    vec_t tv[34];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Serialise a block onto the wire: header bits first, then payload LSB first.
    function automatic void push_block(input logic [1:0] h, input logic [63:0] p);
        bq.push_back(h[0]);
        bq.push_back(h[1]);
        for (int i = 0; i < 64; i++) bq.push_back(p[i]);
    endfunction

    function automatic logic [63:0] pop_word(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (bq.size() > 0) r[i] = bq.pop_front();
        end
        return r;
    endfunction

    task automatic do_reset();
        b64.data_i = '0; b64.slip_i = 1'b0;
        b32.data_i = '0; b32.slip_i = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step64(input logic [63:0] d, input logic s);
        b64.data_i = d;
        b64.slip_i = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step32(input logic [31:0] d);
        b32.data_i = d;
        b32.slip_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Word k (0-based) of the 32-block stream: first word only fills (64),
    // words 1..32 each emit block k-1 leaving 64-2k, word 33 refills from 0.
    task automatic build_table();
        bq.delete();
        for (int b = 0; b < 32; b++) push_block(2'b01, 64'(b));
        for (int k = 0; k < 34; k++) begin
            tv[k].data  = pop_word(64);
            tv[k].slip  = 1'b0;
            tv[k].valid = (k != 0) && (k != 33);
            tv[k].head  = (k == 0) ? 2'b00 : 2'b01;
            tv[k].pay   = (k == 0) ? 64'd0 : (k == 33) ? 64'd31 : 64'(k - 1);
            tv[k].fill  = (k == 33) ? 7'd64 : 7'(64 - 2 * k);
        end
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 34; k++) begin
            step64(tv[k].data, tv[k].slip);
            chk({tag, "_valid"}, b64.valid_o, tv[k].valid);
            chk({tag, "_fill"},  b64.fill_o,  tv[k].fill);
            chk({tag, "_head"},  b64.head_o,  tv[k].head);
            chk({tag, "_data"},  b64.data_o,  tv[k].pay);
        end
    endtask

    logic [1:0]  hd[60];
    logic [63:0] pd[60];
    logic [1:0]  hq[$];
    logic [63:0] pq[$];

    initial begin
        int idx, got, nv;
        logic [63:0] w;
        logic [1:0]  h;
        logic [63:0] p;

        // reset state
        do_reset();
        chk("rst_valid", b64.valid_o, 1'b0);
        chk("rst_fill",  b64.fill_o,  7'd0);
        chk("rst_head",  b64.head_o,  2'b00);
        chk("rst_data",  b64.data_o,  64'd0);
        chk("rst32_fill", b32.fill_o, 7'd0);

        // 32 known blocks in 33 words
        build_table();
        run_table("blk32");

        // asynchronous reset mid-stream at fill 40, then restart from block 0
        do_reset();
        for (int k = 0; k < 13; k++) step64(tv[k].data, 1'b0);
        chk("mid_fill40", b64.fill_o, 7'd40);
        chk("mid_valid",  b64.valid_o, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", b64.valid_o, 1'b0);
        chk("arst_head",  b64.head_o,  2'b00);
        chk("arst_data",  b64.data_o,  64'd0);
        chk("arst_fill",  b64.fill_o,  7'd0);
        #2 reset = 1'b0;
        run_table("restart");

        // slip when cnt = 0, and slip when avail would be exactly 66
        do_reset();
        step64(tv[0].data, 1'b1);
        chk("slip_cnt0_valid", b64.valid_o, 1'b0);
        chk("slip_cnt0_fill",  b64.fill_o,  7'd63);
        do_reset();
        for (int k = 0; k < 32; k++) step64(tv[k].data, 1'b0);
        chk("pre_slip66_fill", b64.fill_o, 7'd2);
        step64(tv[32].data, 1'b1);
        chk("slip66_valid", b64.valid_o, 1'b0);
        chk("slip66_fill",  b64.fill_o,  7'd65);
        step64(tv[33].data, 1'b0);
        chk("after66_valid", b64.valid_o, 1'b1);
        chk("after66_fill",  b64.fill_o,  7'd63);

        // 5 junk bits ahead of the stream, 5 slips: block 3 is the first aligned one
        do_reset();
        bq.delete();
        bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
        bq.push_back(1'b1); bq.push_back(1'b0);
        for (int b = 0; b < 60; b++) begin
            hd[b] = (b % 2 == 1) ? 2'b10 : 2'b01;
            pd[b] = {$urandom, $urandom};
            push_block(hd[b], pd[b]);
        end
        for (int c = 0; c < 5; c++) step64(pop_word(64), 1'b1);
        chk("off_first_valid", b64.valid_o, 1'b1);
        chk("off_first_blk", {b64.head_o, b64.data_o}, {hd[3], pd[3]});
        idx = 4;
        for (int c = 0; c < 40; c++) begin
            step64(pop_word(64), 1'b0);
            if (b64.valid_o) begin
                chk("off_head_legal", (b64.head_o == 2'b01) || (b64.head_o == 2'b10), 1'b1);
                chk("off_blk", {b64.head_o, b64.data_o}, {hd[idx], pd[idx]});
                idx++;
            end
        end
        chk("off_final_idx", idx, 43);

        // long loopback: 10000 random blocks with alternating headers
        do_reset();
        bq.delete();
        for (int b = 0; b < 10000; b++) begin
            h = b[0] ? 2'b10 : 2'b01;
            p = {$urandom, $urandom};
            hq.push_back(h);
            pq.push_back(p);
            push_block(h, p);
        end
        got = 0;
        for (int c = 0; c < 10400 && got < 10000; c++) begin
            step64(pop_word(64), 1'b0);
            if (b64.valid_o) begin
                if (pq.size() == 0) begin
                    chk("loop_extra_block", 1'b1, 1'b0);
                end else begin
                    h = hq.pop_front();
                    p = pq.pop_front();
                    chk("loop_blk", {b64.head_o, b64.data_o}, {h, p});
                end
                got++;
            end
        end
        chk("loop_count", got, 10000);

        // 32-bit PMA: 66 words carry the same 32 blocks, first emit after word 3
        do_reset();
        bq.delete();
        for (int b = 0; b < 32; b++) push_block(2'b01, 64'(b));
        nv = 0;
        for (int k = 0; k < 66; k++) begin
            w = pop_word(32);
            step32(w[31:0]);
            if (k < 2) chk("p32_early_valid", b32.valid_o, 1'b0);
            if (k == 2) begin
                chk("p32_first_valid", b32.valid_o, 1'b1);
                chk("p32_first_fill",  b32.fill_o,  7'd30);
            end
            if (b32.valid_o) begin
                chk("p32_blk", {b32.head_o, b32.data_o}, {2'b01, 64'(nv)});
                nv++;
            end
        end
        chk("p32_count", nv, 32);
        chk("p32_final_fill", b32.fill_o, 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
